uc_ctrl: RTL and testbench
==========================

# uc_ctrl

Control unit for the single-cycle 8-bit CPU datapath: consumes the 6-bit opcode and registered zero flag, drives every datapath control line. Adds a small sequencer on top of the combinational decode: a post-return skip cycle (the stack holds the CALL address, not CALL+1), a HALT state, and a call-depth tracker that halts on stack overflow or underflow. It sits beside the datapath in the CPU top level, wired port-for-port to its control inputs.

## Interface
- STACK_DEPTH, 8: entries in the datapath return stack; call-depth overflow limit.
- CNT_W, 16: width of the retired-instruction counter.

- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction bits [15:10] of the current instruction.
- z  in  1  registered zero flag from the datapath.
- s_inc  out  1  1 = PC+1, 0 = jump target (instr[9:0]).
- s_pila  out  1  1 = next PC from stack top.
- push, pop  out  1 each  stack push of current PC / stack pop.
- we3  out  1  register-file write enable.
- wez  out  1  zero-flag write enable.
- we4  out  1  I/O register write enable.
- s_inm  out  2  write-back select: 00 ALU, 01 immediate instr[11:4], 10 I/O read.
- op_alu  out  3  ALU operation.
- halted  out  1  1 while in HALT.
- stack_err  out  1  sticky: overflow or underflow caused the halt.
- retired  out  CNT_W  count of executed (non-skipped) instructions.

## Operation
- Opcode map (opcode[5:0]):
  - 0ppp_xx: ALU op; op_alu=ppp, we3=1, wez=1, s_inm=00, s_inc=1.
  - 10_00xx: LI; we3=1, s_inm=01, s_inc=1.
  - 10_01xx: IN; we3=1, s_inm=10, s_inc=1.
  - 10_10xx: OUT; we4=1, s_inc=1.
  - 11_0000 JMP: s_inc=0. 11_0001 JZ: s_inc=~z. 11_0010 JNZ: s_inc=z.
  - 11_0011 CALL: push=1, s_inc=0, depth+1.
  - 11_0100 RET: pop=1, s_pila=1, depth-1, next state SKIP.
  - 11_1111 HALT: next state HALT. Instr[9:0] of HALT equals its own address (assembler rule).
  - All other codes: NOP, s_inc=1, no writes.
- Defaults for unlisted outputs: 0; s_inc=1, op_alu=000, s_inm=00.
- States: RUN, SKIP, HALT.
  - RUN: decode as above.
  - SKIP: the fetched instruction (the returning CALL) is suppressed: all writes/push/pop 0, s_pila=0, s_inc=1; next state RUN. Not counted in retired.
  - HALT: s_inc=0, all writes/push/pop 0; PC re-selects the HALT address. Left only by reset.
- Depth counter 0..STACK_DEPTH, width clog2(STACK_DEPTH+1).
  - CALL at depth==STACK_DEPTH: overflow; push suppressed, stack_err=1, next state HALT.
  - RET at depth==0: underflow; pop/s_pila suppressed, stack_err=1, next state HALT.
- retired increments once per RUN-state instruction including HALT itself; wraps modulo 2^CNT_W.

## Timing
- Decode is combinational from opcode, z, state (Mealy); state, depth, retired, stack_err update at the rising edge.
- Instruction memory read is combinational from PC; every instruction completes in one cycle; RET costs 2 cycles (RET + SKIP).
- JZ/JNZ sample z as registered by the previous flag-writing instruction.
- Reset (asserted any time, including mid-SKIP or in HALT): state=RUN, depth=0, retired=0, stack_err=0, halted=0; all write enables, push, pop, s_pila are 0 while reset is low.
- First rising edge after release executes the instruction at PC=0.

## Structure
- Package uc_pkg: opcode constants, state enum (RUN, SKIP, HALT), s_inm encodings (SINM_ALU, SINM_IMM, SINM_IO).
- Sub-module uc_decode: pure combinational opcode/z → control vector; uc_ctrl adds the FSM, depth counter, suppression and retired counter.

## Test plan
- ALU opcode 0_101_00 in RUN -> op_alu=101, we3=1, wez=1, s_inm=00, s_inc=1; retired 0→1.
- JZ with z=1 -> s_inc=0; JZ with z=0 -> s_inc=1; JNZ mirrored.
- CALL then RET -> CALL cycle push=1,s_inc=0, depth 0→1; RET cycle pop=1,s_pila=1; next cycle SKIP: opcode 11_0011 presented, push=0, s_inc=1, retired unchanged; then RUN.
- 8 nested CALLs then a 9th -> 9th has push=0, stack_err=1, halted=1 next cycle; RET at depth 0 from reset -> pop=0, stack_err=1, halted=1.
- HALT opcode -> halted=1, s_inc=0, we3/we4/wez stay 0 for 20 cycles with ALU opcodes forced on input.
- Assert reset during SKIP and during HALT -> all outputs at reset values immediately (async); after release first instruction decoded in RUN, retired=0.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared constants and types for the 8-bit CPU control unit.
package uc_pkg;

    localparam logic [5:0] OP_JMP  = 6'b110000;
    localparam logic [5:0] OP_JZ   = 6'b110001;
    localparam logic [5:0] OP_JNZ  = 6'b110010;
    localparam logic [5:0] OP_CALL = 6'b110011;
    localparam logic [5:0] OP_RET  = 6'b110100;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [3:0] GRP_LI  = 4'b1000;
    localparam logic [3:0] GRP_IN  = 4'b1001;
    localparam logic [3:0] GRP_OUT = 4'b1010;

    localparam logic [1:0] SINM_ALU = 2'b00;
    localparam logic [1:0] SINM_IMM = 2'b01;
    localparam logic [1:0] SINM_IO  = 2'b10;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SKIP = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic       s_inc;
        logic       s_pila;
        logic       push;
        logic       pop;
        logic       we3;
        logic       wez;
        logic       we4;
        logic [1:0] s_inm;
        logic [2:0] op_alu;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        s_inc: 1'b1, s_pila: 1'b0, push: 1'b0, pop: 1'b0,
        we3: 1'b0, wez: 1'b0, we4: 1'b0,
        s_inm: SINM_ALU, op_alu: 3'b000
    };

    // PC keeps re-selecting the HALT instruction's own address
    localparam ctrl_t CTRL_HOLD = '{
        s_inc: 1'b0, s_pila: 1'b0, push: 1'b0, pop: 1'b0,
        we3: 1'b0, wez: 1'b0, we4: 1'b0,
        s_inm: SINM_ALU, op_alu: 3'b000
    };

endpackage

// File: rtl/uc_if.sv
// Control bundle between the control unit (master) and datapath (slave).
interface uc_if #(
    parameter int CNT_W = 16
);
    import uc_pkg::*;

    logic [5:0]       opcode;
    logic             z;
    logic             s_inc;
    logic             s_pila;
    logic             push;
    logic             pop;
    logic             we3;
    logic             wez;
    logic             we4;
    logic [1:0]       s_inm;
    logic [2:0]       op_alu;
    logic             halted;
    logic             stack_err;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, z,
        output s_inc, s_pila, push, pop,
        output we3, wez, we4, s_inm, op_alu,
        output halted, stack_err, retired
    );

    modport slave (
        output opcode, z,
        input  s_inc, s_pila, push, pop,
        input  we3, wez, we4, s_inm, op_alu,
        input  halted, stack_err, retired
    );

endinterface

// File: rtl/uc_decode.sv
// Pure combinational opcode/zero-flag decode into a control vector.
module uc_decode
    import uc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       z,
    output ctrl_t      ctrl,
    output logic       is_call,
    output logic       is_ret,
    output logic       is_halt
);

    always_comb begin
        ctrl    = CTRL_NOP;
        is_call = 1'b0;
        is_ret  = 1'b0;
        is_halt = 1'b0;
        unique case (1'b1)
            !opcode[5]: begin
                ctrl.op_alu = opcode[4:2];
                ctrl.we3    = 1'b1;
                ctrl.wez    = 1'b1;
            end
            opcode[5:2] == GRP_LI: begin
                ctrl.we3   = 1'b1;
                ctrl.s_inm = SINM_IMM;
            end
            opcode[5:2] == GRP_IN: begin
                ctrl.we3   = 1'b1;
                ctrl.s_inm = SINM_IO;
            end
            opcode[5:2] == GRP_OUT: ctrl.we4 = 1'b1;
            opcode == OP_JMP: ctrl.s_inc = 1'b0;
            opcode == OP_JZ:  ctrl.s_inc = ~z;
            opcode == OP_JNZ: ctrl.s_inc = z;
            opcode == OP_CALL: begin
                ctrl.push  = 1'b1;
                ctrl.s_inc = 1'b0;
                is_call    = 1'b1;
            end
            opcode == OP_RET: begin
                ctrl.pop    = 1'b1;
                ctrl.s_pila = 1'b1;
                is_ret      = 1'b1;
            end
            opcode == OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/uc_ctrl.sv
// Control unit: decode plus RUN/SKIP/HALT sequencer, call-depth guard
// and retired-instruction counter.
module uc_ctrl
    import uc_pkg::*;
#(
    parameter int STACK_DEPTH = 8,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic reset,
    uc_if.master bus
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam logic [DW-1:0] DMAX = DW'(STACK_DEPTH);

    state_t           state;
    logic [DW-1:0]    depth;
    logic [CNT_W-1:0] retired;
    logic             stack_err;
    logic             halted;

    ctrl_t dec;
    ctrl_t ctrl;
    logic  is_call;
    logic  is_ret;
    logic  is_halt;
    logic  ovf;
    logic  unf;

    uc_decode u_decode (
        .opcode  (bus.opcode),
        .z       (bus.z),
        .ctrl    (dec),
        .is_call (is_call),
        .is_ret  (is_ret),
        .is_halt (is_halt)
    );

    assign ovf = is_call && (depth == DMAX);
    assign unf = is_ret && (depth == '0);

    // Reset is also applied here so writes drop the instant it asserts
    always_comb begin
        ctrl = CTRL_NOP;
        if (reset) begin
            case (state)
                RUN: begin
                    ctrl = dec;
                    if (ovf) ctrl.push = 1'b0;
                    if (unf) begin
                        ctrl.pop    = 1'b0;
                        ctrl.s_pila = 1'b0;
                    end
                end
                SKIP:    ctrl = CTRL_NOP;
                HALT:    ctrl = CTRL_HOLD;
                default: ctrl = CTRL_NOP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            depth     <= '0;
            retired   <= '0;
            stack_err <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    retired <= retired + 1'b1;
                    if (is_halt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (ovf || unf) begin
                        state     <= HALT;
                        halted    <= 1'b1;
                        stack_err <= 1'b1;
                    end else if (is_call) begin
                        depth <= depth + 1'b1;
                    end else if (is_ret) begin
                        depth <= depth - 1'b1;
                        state <= SKIP;
                    end
                end
                SKIP: state <= RUN;
                HALT: state <= HALT;
                default: state <= RUN;
            endcase
        end
    end

    assign bus.s_inc     = ctrl.s_inc;
    assign bus.s_pila    = ctrl.s_pila;
    assign bus.push      = ctrl.push;
    assign bus.pop       = ctrl.pop;
    assign bus.we3       = ctrl.we3;
    assign bus.wez       = ctrl.wez;
    assign bus.we4       = ctrl.we4;
    assign bus.s_inm     = ctrl.s_inm;
    assign bus.op_alu    = ctrl.op_alu;
    assign bus.halted    = halted;
    assign bus.stack_err = stack_err;
    assign bus.retired   = retired;

endmodule

// File: tb/tb_uc_ctrl.sv
// Scoreboard bench for uc_ctrl: directed scenarios then random opcodes
// checked against a call-stack reference model.
module tb_uc_ctrl;

    typedef struct packed {
        logic        s_inc;
        logic        s_pila;
        logic        push;
        logic        pop;
        logic        we3;
        logic        wez;
        logic        we4;
        logic [1:0]  s_inm;
        logic [2:0]  op_alu;
        logic        halted;
        logic        stack_err;
        logic [15:0] retired;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    uc_if #(.CNT_W(16)) bus ();

    uc_ctrl #(.STACK_DEPTH(8), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    bit          m_halt = 1'b0;
    bit          m_skip = 1'b0;
    bit          m_err  = 1'b0;
    logic [15:0] m_ret  = '0;
    int          m_stk[$];

    task automatic step(input logic [5:0] op, input logic zz, input logic rn);
        obs_t e;
        @(negedge clk);
        #1;
        bus.opcode = op;
        bus.z      = zz;
        rst_n      = rn;
        cyc++;
        if (!rn) begin
            m_halt = 0; m_skip = 0; m_err = 0; m_ret = '0;
            m_stk.delete();
        end
        e = '0;
        e.s_inc     = 1'b1;
        e.halted    = m_halt;
        e.stack_err = m_err;
        e.retired   = m_ret;
        if (!rn) begin
            // reset values only
        end else if (m_halt) begin
            e.s_inc = 1'b0;
        end else if (m_skip) begin
            m_skip = 0;
        end else begin
            m_ret = m_ret + 16'd1;
            if (op[5] == 1'b0) begin
                e.op_alu = op[4:2]; e.we3 = 1; e.wez = 1;
            end else if (op[5:2] == 4'b1000) begin
                e.we3 = 1; e.s_inm = 2'b01;
            end else if (op[5:2] == 4'b1001) begin
                e.we3 = 1; e.s_inm = 2'b10;
            end else if (op[5:2] == 4'b1010) begin
                e.we4 = 1;
            end else if (op == 6'b110000) begin
                e.s_inc = 0;
            end else if (op == 6'b110001) begin
                e.s_inc = ~zz;
            end else if (op == 6'b110010) begin
                e.s_inc = zz;
            end else if (op == 6'b110011) begin
                e.s_inc = 0;
                if (m_stk.size() == 8) begin
                    m_err = 1; m_halt = 1;
                end else begin
                    e.push = 1;
                    m_stk.push_back(cyc);
                end
            end else if (op == 6'b110100) begin
                if (m_stk.size() == 0) begin
                    m_err = 1; m_halt = 1;
                end else begin
                    e.pop = 1; e.s_pila = 1;
                    void'(m_stk.pop_back());
                    m_skip = 1;
                end
            end else if (op == 6'b111111) begin
                m_halt = 1;
            end
        end
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        obs_t g;
        obs_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {bus.s_inc, bus.s_pila, bus.push, bus.pop,
                     bus.we3, bus.wez, bus.we4, bus.s_inm, bus.op_alu,
                     bus.halted, bus.stack_err, bus.retired};
                n_cmp++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL ctrl cyc=%0d op=%b z=%b rst_n=%b got=%h exp=%h",
                             cyc, bus.opcode, bus.z, rst_n, g, e);
                end
            end
        end
    end

    function automatic logic [5:0] rand_op();
        int r;
        r = $urandom_range(0, 19);
        if (r <= 5)  return {1'b0, 5'($urandom)};
        if (r == 6)  return {4'b1000, 2'($urandom)};
        if (r == 7)  return {4'b1001, 2'($urandom)};
        if (r == 8)  return {4'b1010, 2'($urandom)};
        if (r == 9)  return 6'b110000;
        if (r == 10) return 6'b110001;
        if (r == 11) return 6'b110010;
        if (r <= 14) return 6'b110011;
        if (r <= 16) return 6'b110100;
        if (r == 17) return ($urandom_range(0, 3) == 0) ? 6'b111111 : 6'b000000;
        if (r == 18) return {4'b1011, 2'($urandom)};
        return {2'b11, 4'($urandom_range(5, 14))};
    endfunction

    initial begin : stim
        int halt_cnt;
        bus.opcode = '0;
        bus.z      = 1'b0;
        step(6'b000000, 0, 0);
        step(6'b000000, 0, 0);
        // ALU, conditional jumps
        step(6'b010100, 0, 1);
        step(6'b110001, 1, 1);
        step(6'b110001, 0, 1);
        step(6'b110010, 1, 1);
        step(6'b110010, 0, 1);
        // CALL, RET, SKIP with returning CALL presented, then reset mid-SKIP
        step(6'b110011, 0, 1);
        step(6'b110100, 0, 1);
        step(6'b110011, 0, 1);
        step(6'b100001, 0, 1);
        step(6'b110011, 0, 1);
        step(6'b110100, 0, 1);
        step(6'b110011, 0, 0);
        step(6'b010000, 0, 1);
        // overflow after 8 nested CALLs
        for (int i = 0; i < 9; i++) step(6'b110011, 0, 1);
        step(6'b000100, 0, 1);
        step(6'b000100, 0, 0);
        // underflow from reset
        step(6'b110100, 0, 1);
        step(6'b110100, 0, 1);
        step(6'b000000, 0, 0);
        // HALT, then ALU opcodes forced, then reset while halted
        step(6'b111111, 0, 1);
        for (int i = 0; i < 20; i++) step({1'b0, 5'($urandom)}, 1'($urandom), 1);
        step(6'b011100, 0, 0);
        step(6'b011100, 0, 1);
        // random traffic with periodic resets
        halt_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_halt) halt_cnt++;
            else halt_cnt = 0;
            if (halt_cnt > 4 || $urandom_range(0, 79) == 0) begin
                step(rand_op(), 1'($urandom), 0);
                halt_cnt = 0;
            end else begin
                step(rand_op(), 1'($urandom), 1);
            end
        end
        repeat (3) @(negedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, exp 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
